// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// the NOP instruction word and the register index width.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W     = 3;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    RUN      = 3'd1,
    MEM_WAIT = 3'd2,
    REDIRECT = 3'd3,
    HALT     = 3'd4
  } state_t;

endpackage

// File: rtl/pipe_hazard_det.sv
// Combinational load-use detector: the ID instruction reads a register
// that the load currently in EX has not yet produced.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_rs_vld,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rt_vld,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit   = id_rs_vld && (id_rs == ex_rd);
    rt_hit   = id_rt_vld && (id_rt == ex_rd);
    load_use = ex_memread && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with HALT handling.
// Optional performance counters enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_mem_stall,
  input  logic             dm_stall,
  input  logic             id_rs_vld,
  input  logic             id_rt_vld,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             id_halt,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state, state_nxt;
  state_t saved, saved_nxt;
  state_t eff_state;
  logic   load_use;

  pipe_hazard_det u_hazard (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs_vld  (id_rs_vld),
    .id_rs      (id_rs),
    .id_rt_vld  (id_rt_vld),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      saved <= INIT;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
    end
  end

  // On the cycle dm_stall drops, behave as the saved state so a held
  // br_taken (or a pending redirect) acts with no extra latency.
  always_comb begin
    eff_state = state;
    if (state == MEM_WAIT && !dm_stall)
      eff_state = saved;
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    state_nxt   = eff_state;
    saved_nxt   = saved;

    case (eff_state)
      INIT: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        state_nxt  = RUN;
      end

      MEM_WAIT: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end

      RUN: begin
        if (dm_stall) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          saved_nxt   = RUN;
          state_nxt   = MEM_WAIT;
        end else if (br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = REDIRECT;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else if (if_mem_stall) begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
        end else if (id_halt) begin
          state_nxt = HALT;
        end
      end

      REDIRECT: begin
        if (dm_stall) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          saved_nxt   = REDIRECT;
          state_nxt   = MEM_WAIT;
        end else begin
          ifid_flush = 1'b1;
          pc_stall   = if_mem_stall;
          if (!if_mem_stall)
            state_nxt = RUN;
        end
      end

      HALT: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
      end

      default: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        state_nxt  = INIT;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (state != HALT) begin
      if (pc_stall && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (ifid_flush && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counter expectations follow
// whether PIPE_CTRL_PERF_CNT_EN is defined for the build.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, halted}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_INIT = 7'b1000100;
  localparam logic [6:0] O_IMS  = 7'b1000100;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_BR   = 7'b0000110;
  localparam logic [6:0] O_MW   = 7'b1111000;
  localparam logic [6:0] O_RDW  = 7'b1000100;
  localparam logic [6:0] O_RD   = 7'b0000100;
  localparam logic [6:0] O_HALT = 7'b1100011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_mem_stall, dm_stall, id_rs_vld, id_rt_vld;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             ex_memread, br_taken, id_halt;
  logic             pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic             ifid_flush, idex_flush, halted;
  logic [15:0]      stall_cnt, flush_cnt;
  logic [6:0]       outs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                 ifid_flush, idex_flush, halted};

  pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_mem_stall (if_mem_stall),
    .dm_stall     (dm_stall),
    .id_rs_vld    (id_rs_vld),
    .id_rt_vld    (id_rt_vld),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .br_taken     (br_taken),
    .id_halt      (id_halt),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .exmem_stall  (exmem_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    if_mem_stall = 1'b0; dm_stall = 1'b0; br_taken = 1'b0; id_halt = 1'b0;
    ex_memread = 1'b0; ex_rd = '0;
    id_rs_vld = 1'b0; id_rs = '0; id_rt_vld = 1'b0; id_rt = '0;
  endtask

  // Inputs are already set; check mid-cycle, then advance one clock.
  task automatic tick(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check(tag, {9'd0, outs}, {9'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int unsigned s, input int unsigned f);
    check({tag, "_stall_cnt"}, stall_cnt, PERF ? s[15:0] : 16'd0);
    check({tag, "_flush_cnt"}, flush_cnt, PERF ? f[15:0] : 16'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_outs", {9'd0, outs}, {9'd0, O_INIT});
    check_cnt("rst", 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    tick("post_rst_init", O_INIT);
    tick("post_rst_run", O_IDLE);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    #3;
    check("reset_outs", {9'd0, outs}, {9'd0, O_INIT});
    check_cnt("reset", 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("init", O_INIT);
    tick("run0", O_IDLE);
    check_cnt("after_init", 1, 1);

    // load-use
    ex_memread = 1'b1; ex_rd = 3'd3; id_rs_vld = 1'b1; id_rs = 3'd3;
    tick("lu_rs", O_LU);
    ex_memread = 1'b0;
    tick("lu_after", O_IDLE);
    ex_memread = 1'b1; id_rs_vld = 1'b0;
    tick("lu_novld", O_IDLE);
    id_rt_vld = 1'b1; id_rt = 3'd5; ex_rd = 3'd5;
    tick("lu_rt", O_LU);
    ex_rd = 3'd4; id_rs_vld = 1'b1;
    tick("lu_miss", O_IDLE);

    // priorities
    ex_rd = 3'd3; if_mem_stall = 1'b1;
    tick("lu_over_ims", O_LU);
    clr(); if_mem_stall = 1'b1;
    tick("ims", O_IMS);
    id_halt = 1'b1;
    tick("ims_over_halt", O_IMS);
    clr();
    tick("still_run", O_IDLE);

    // branch with instruction memory stalled for two cycles
    br_taken = 1'b1; if_mem_stall = 1'b1;
    tick("br", O_BR);
    br_taken = 1'b0;
    tick("redir_wait", O_RDW);
    br_taken = 1'b1; if_mem_stall = 1'b0;
    tick("redir_ignore_br", O_RD);
    clr();
    tick("br_done", O_IDLE);

    // dm_stall freezes a taken branch for four cycles
    dm_stall = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 4; i++) tick("dm_freeze", O_MW);
    dm_stall = 1'b0;
    tick("dm_release_br", O_BR);
    br_taken = 1'b0;
    tick("dm_redir", O_RD);
    tick("dm_done", O_IDLE);

    // pending redirect survives MEM_WAIT
    br_taken = 1'b1;
    tick("pend_br", O_BR);
    br_taken = 1'b0; if_mem_stall = 1'b1;
    tick("pend_rdw", O_RDW);
    dm_stall = 1'b1;
    tick("pend_mw0", O_MW);
    tick("pend_mw1", O_MW);
    dm_stall = 1'b0;
    tick("pend_back_rdw", O_RDW);
    if_mem_stall = 1'b0;
    tick("pend_rd", O_RD);
    tick("pend_done", O_IDLE);
    check_cnt("pre_halt", 15, 12);

    // HALT is sticky and counters freeze
    id_halt = 1'b1;
    tick("halt_entry", O_IDLE);
    id_halt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      dm_stall = i[0];
      br_taken = i[1];
      tick("halted", O_HALT);
    end
    check_cnt("halt_frozen", 15, 12);
    reset_pulse();

    // reset while a redirect is parked in MEM_WAIT
    br_taken = 1'b1;
    tick("rw_br", O_BR);
    br_taken = 1'b0; dm_stall = 1'b1;
    tick("rw_mw", O_MW);
    reset_pulse();
    tick("rw_no_redirect", O_IDLE);
    check_cnt("rw_after", 1, 1);

    // counter saturation
    if_mem_stall = 1'b1;
    repeat (65530) @(posedge clk);
    #1;
    check_cnt("near_max", 65531, 65531);
    repeat (5) @(posedge clk);
    #1;
    check_cnt("sat", 65535, 65535);
    repeat (5) @(posedge clk);
    #1;
    check_cnt("sat_hold", 65535, 65535);
    clr();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port if_mem_stall, input, 1 bit: instruction memory has not returned the fetch this cycle.
REQ-004 SHALL have port dm_stall, input, 1 bit: data memory busy; the whole pipe must freeze.
REQ-005 SHALL have ports id_rs_vld and id_rt_vld, input, 1 bit each: the ID instruction reads the corresponding operand.
REQ-006 SHALL have ports id_rs and id_rt, input, 3 bits each: source register indices of the ID instruction.
REQ-007 SHALL have port ex_memread, input, 1 bit: the EX instruction is a load.
REQ-008 SHALL have port ex_rd, input, 3 bits: load destination index.
REQ-009 SHALL have port br_taken, input, 1 bit: a control transfer resolved in EX redirects the PC.
REQ-010 SHALL have port id_halt, input, 1 bit: HALT decoded in ID.
REQ-011 SHALL have ports pc_stall, ifid_stall, idex_stall and exmem_stall, output, 1 bit each: hold the PC / stage register.
REQ-012 SHALL have ports ifid_flush and idex_flush, output, 1 bit each: load NOP (16'h0800) / bubble into the stage.
REQ-013 SHALL have port halted, output, 1 bit: the processor is halted.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, 16 bits each: performance counters (see Configuration).

Function
REQ-015 SHALL implement FSM states INIT, RUN, MEM_WAIT, REDIRECT and HALT; all outputs are decoded from state plus inputs, with no extra output latency.
REQ-016 SHALL apply event priority dm_stall > br_taken > load-use > if_mem_stall > id_halt.
REQ-017 SHALL, in state INIT, assert pc_stall and ifid_flush for exactly 1 cycle, then go to RUN.
REQ-018 SHALL, when dm_stall=1 in any state except HALT and INIT, assert all four stall outputs, keep both flush outputs at 0, and enter/stay in MEM_WAIT.
REQ-019 SHALL, on MEM_WAIT exit, return to the state held before entry (saved register), including a pending REDIRECT.
REQ-020 SHALL, when br_taken=1 in RUN, assert ifid_flush and idex_flush with pc_stall=0 (PC loads the target), and enter REDIRECT.
REQ-021 SHALL, in REDIRECT, keep ifid_flush=1 and pc_stall=if_mem_stall until if_mem_stall=0, then return to RUN.
REQ-022 SHALL ignore a br_taken that arrives while in REDIRECT (it is a flushed, wrong-path instruction).
REQ-023 SHALL define load-use as ex_memread && ((id_rs_vld && id_rs==ex_rd) || (id_rt_vld && id_rt==ex_rd)).
REQ-024 SHALL, on load-use in RUN, assert pc_stall, ifid_stall and idex_flush for that cycle only; no state change.
REQ-025 SHALL, on if_mem_stall alone in RUN, assert pc_stall and ifid_flush (NOP into ID); the downstream pipe keeps flowing.
REQ-026 SHALL, on id_halt in RUN with no higher-priority event, enter HALT.
REQ-027 SHALL, in HALT, assert pc_stall, ifid_stall and halted permanently; idex_flush=1 so the pipe drains; HALT exits only on reset.
REQ-028 SHALL, for simultaneous dm_stall and br_taken, freeze first; the redirect is taken on the first cycle after dm_stall=0, because br_taken is held by the frozen EX stage.

Reset
REQ-029 SHALL, on rst_n=0, immediately put the FSM in INIT, clear the saved state, and clear both counters.
REQ-030 SHALL hold output values during reset as follows: pc_stall=1, ifid_flush=1, all other control outputs 0, halted=0.
REQ-031 SHALL treat reset mid-MEM_WAIT, mid-REDIRECT or in HALT as discarding all pending events.

Configuration
REQ-032 SHALL, with PIPE_CTRL_PERF_CNT_EN defined, increment stall_cnt on every cycle pc_stall=1 and flush_cnt on every cycle ifid_flush=1, both saturating at 16'hFFFF and both frozen in HALT.
REQ-033 SHALL, without PIPE_CTRL_PERF_CNT_EN, drive stall_cnt and flush_cnt to constant 0, remove the counter flops, and keep the port list unchanged.

Structure
REQ-034 SHALL place in shared package pipe_ctrl_pkg: the FSM state encoding, the NOP constant 16'h0800, and the register index width (3).
REQ-035 SHALL put the load-use comparison in combinational sub-module pipe_hazard_det; the FSM and counters stay in pipe_ctrl.

Verification
REQ-036 SHALL cover release of rst_n: cycle 0 pc_stall=1 and ifid_flush=1 (INIT); cycle 1 all outputs 0 (RUN).
REQ-037 SHALL cover ex_memread=1, ex_rd=3, id_rs_vld=1, id_rs=3: exactly 1 cycle of pc_stall=ifid_stall=idex_flush=1; with id_rs_vld=0, no stall.
REQ-038 SHALL cover br_taken=1 with if_mem_stall=1 for 2 cycles: ifid_flush=1 for 3 cycles, idex_flush=1 for 1 cycle, then RUN.
REQ-039 SHALL cover dm_stall=1 for 4 cycles with br_taken=1: all stalls=1 and flushes=0 for 4 cycles, then the redirect flush.
REQ-040 SHALL cover id_halt=1: halted=1 the next cycle and stays 1 for 100 cycles; rst_n pulse clears it to INIT.
REQ-041 SHALL cover, with PIPE_CTRL_PERF_CNT_EN defined, stall_cnt preloaded near max plus 5 stall cycles: holds 16'hFFFF.
